uart_recv: RTL and testbench
============================

# uart_recv

- UART receive path: deserialises 8N1 frames from the host on USB_RX, sampled at 16× oversampling on uart_sampling_clk.
- Sits beside the transmitter that sends ACK/RESEND and feeds received bytes to the core through a one-entry output buffer with valid/ready handshake.
- Drives USB_CTS for host flow control.
- Flags framing errors and overruns, and decodes ACK/RESEND bytes coming from the host.

## Interface
- OVERSAMPLE, 16, samples per bit; power of two, ≥ 8; mid-bit index MID = OVERSAMPLE/2
- uart_sampling_clk  input  1  sole clock, OVERSAMPLE × baud
- rst  input  1  asynchronous, active-high reset
- USB_RX  input  1  serial line, idle high, asynchronous to clock
- data_ready  input  1  consumer accepts data_out this cycle
- data_out  output  8  received byte, LSB first on the wire
- data_valid  output  1  data_out holds an unconsumed byte
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte dropped because buffer full
- rx_ack  output  1  one-cycle pulse with load of byte 8'hAA
- rx_resend  output  1  one-cycle pulse with load of byte 8'hCC
- USB_CTS  output  1  active-low clear-to-send; equals data_valid, so high = do not send

## Operation
- USB_RX passes through a 2-flop synchroniser (flops reset to 1); all logic uses rx_s.
- States: s_idle, s_start, s_data, s_stop. sample_count is log2(OVERSAMPLE) bits; bit_count is 3 bits.
- s_idle: when rx_s == 0, go to s_start with sample_count = 1; the detect cycle counts as sample 0.
- s_start:
  - At sample_count == MID, if the bit decision is 1, treat it as a false start and return to s_idle.
  - At sample_count == OVERSAMPLE-1, go to s_data with sample_count = 0 and bit_count = 0.
- s_data:
  - At MID, shift the bit decision into shift_reg[7] (right shift, LSB arrives first).
  - At OVERSAMPLE-1, increment bit_count.
  - After bit 7 completes, go to s_stop with sample_count = 0.
- s_stop:
  - At MID, decide the stop bit and return to s_idle in the same cycle, giving early resync for back-to-back frames.
  - Stop = 1 → good byte; stop = 0 → frame_err pulse, byte discarded, no data_valid.
- Good-byte load:
  - If data_valid == 0, or data_ready == 1 in the same cycle: load data_out, set data_valid, pulse rx_ack/rx_resend on a match.
  - Otherwise: overrun pulse, new byte dropped, buffer unchanged.
- Handshake: data_valid && data_ready clears data_valid next cycle unless a new byte loads in that same cycle.
- Counters wrap modulo width. sample_count is reset to 0 on every state change listed above.
- Reset mid-frame: the frame is abandoned. The FSM restarts in s_idle and needs a fresh falling edge.

## Timing
- Reset values: data_out = 0, data_valid = 0, frame_err = 0, overrun = 0, rx_ack = 0, rx_resend = 0, USB_CTS = 0, state s_idle.
- Synchroniser latency is 2 cycles from the USB_RX edge to rx_s.
- data_valid, data_out and the status pulses are registered. They assert the cycle after the stop-bit decision, i.e. 1 cycle after stop MID, which is ≈ 9.5 bit times + 3 cycles after the start edge.
- USB_CTS rises in the same cycle as data_valid and falls the cycle after the handshake.
- The host may already be mid-frame when CTS rises; that byte is received or counted as overrun, never corrupted.

## Configuration
- UART_RECV_MAJORITY_EN defined: the bit decision is the 2-of-3 majority of rx_s at sample indices MID-1, MID and MID+1, and the decision is made at MID+1.
  - All "at MID" actions above move to MID+1.
  - The start-bit check uses the same vote.
- Not defined: the bit decision is rx_s at MID only.
- Frame timing is otherwise identical.

## Structure
- uart_pkg: ACK = 8'hAA, RESEND = 8'hCC, the state enum type shared with the transmitter, and the default OVERSAMPLE.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset-to-1. Reusable for USB_RTS in the transmitter.

## Test plan
- Frame 0x5A at 16 samples/bit, data_ready held 1 → data_valid pulses with data_out = 0x5A; no frame_err or overrun.
- Frame 0xAA, then frame 0xCC → rx_ack on the first load and rx_resend on the second; data_out = 0xAA then 0xCC.
- 4-cycle low glitch on USB_RX → no data_valid, FSM back in s_idle, and the next valid frame 0x33 is received correctly.
- Frame 0x81 with stop bit forced low → frame_err pulse, data_valid stays 0, and the following frame 0x7E is received.
- data_ready held 0, frames 0x11 then 0x22 → data_out = 0x11, USB_CTS = 1, overrun pulse on 0x22; releasing data_ready then clears data_valid and USB_CTS.
- rst asserted mid-frame after bit 3 → all outputs at reset values; the next full frame 0xF0 is received correctly.
- With UART_RECV_MAJORITY_EN: a one-sample glitch at MID in every data bit of 0x00 still yields 0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: ACK/RESEND codes, the line-state enum and the default oversampling ratio.
package uart_pkg;

  localparam int         OVERSAMPLE_DEF = 16;
  localparam logic [7:0] ACK            = 8'hAA;
  localparam logic [7:0] RESEND         = 8'hCC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_recv_if.sv
// Receiver-to-core bundle: one-entry output buffer handshake plus the one-cycle status pulses.
interface uart_recv_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       rx_ack;
  logic       rx_resend;

  modport master (output data_out, data_valid, frame_err, overrun, rx_ack, rx_resend,
                  input  data_ready);
  modport slave  (input  data_out, data_valid, frame_err, overrun, rx_ack, rx_resend,
                  output data_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high line; both flops reset to 1.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff_q <= 2'b11;
    else       ff_q <= {ff_q[0], async_i};
  end

  assign sync_o = ff_q[1];

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver at OVERSAMPLE x baud with a one-entry valid/ready output buffer.
// Define UART_RECV_MAJORITY_EN for a 2-of-3 vote around mid-bit (decision at MID+1).
module uart_recv
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic        uart_sampling_clk,
  input  logic        rst,
  input  logic        USB_RX,
  output logic        USB_CTS,
  uart_recv_if.master rx_if
);

  localparam int             SCW  = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] LAST = SCW'(OVERSAMPLE - 1);
`ifdef UART_RECV_MAJORITY_EN
  localparam logic [SCW-1:0] DEC  = SCW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [SCW-1:0] DEC  = SCW'(OVERSAMPLE / 2);
`endif

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_START = S_START;
  localparam logic [1:0] ST_DATA  = S_DATA;
  localparam logic [1:0] ST_STOP  = S_STOP;

  logic           rx_s;
  logic           bit_dec;
  logic [1:0]     state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [2:0]     bc_q, bc_d;
  logic [7:0]     sh_q, sh_d;
  logic           stop_dec, good, load;
  logic [7:0]     dout_q;
  logic           valid_q, ferr_q, ovr_q, ack_q, res_q;

  uart_rx_sync u_sync (
    .clk_i  (uart_sampling_clk),
    .rst_i  (rst),
    .async_i(USB_RX),
    .sync_o (rx_s)
  );

`ifdef UART_RECV_MAJORITY_EN
  // hist_q[1]/hist_q[0] hold samples MID-1/MID when the vote is taken at MID+1
  logic [1:0] hist_q;
  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  end
  assign bit_dec = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign bit_dec = rx_s;
`endif

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q + 1'b1;
    bc_d     = bc_q;
    sh_d     = sh_q;
    stop_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sc_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          sc_d    = SCW'(1);
        end
      end
      ST_START: begin
        if (sc_q == DEC && bit_dec) begin
          state_d = ST_IDLE;
          sc_d    = '0;
        end else if (sc_q == LAST) begin
          state_d = ST_DATA;
          sc_d    = '0;
          bc_d    = 3'd0;
        end
      end
      ST_DATA: begin
        if (sc_q == DEC) sh_d = {bit_dec, sh_q[7:1]};
        if (sc_q == LAST) begin
          bc_d = bc_q + 3'd1;
          if (bc_q == 3'd7) begin
            state_d = ST_STOP;
            sc_d    = '0;
          end
        end
      end
      ST_STOP: begin
        // Leave at the stop decision so a back-to-back start edge is caught early
        if (sc_q == DEC) begin
          stop_dec = 1'b1;
          state_d  = ST_IDLE;
          sc_d     = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sc_d    = '0;
      end
    endcase
  end

  assign good = stop_dec & bit_dec;
  assign load = good & (~valid_q | rx_if.data_ready);

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      bc_q    <= 3'd0;
      sh_q    <= 8'h00;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ack_q   <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      sh_q    <= sh_d;
      if (load) dout_q <= sh_q;
      valid_q <= load | (valid_q & ~rx_if.data_ready);
      ferr_q  <= stop_dec & ~bit_dec;
      ovr_q   <= good & ~load;
      ack_q   <= load & (sh_q == ACK);
      res_q   <= load & (sh_q == RESEND);
    end
  end

  assign rx_if.data_out   = dout_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = ovr_q;
  assign rx_if.rx_ack     = ack_q;
  assign rx_if.rx_resend  = res_q;
  assign USB_CTS          = valid_q;

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: vector table, hand-written corner sequences and random frames.
module tb_uart_recv;
  import uart_pkg::*;

  localparam int OS      = 16;
  localparam int LATENCY = 155;  // start edge to data_valid: 9.5 bit times + 3 cycles

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic usb_rx = 1'b1;
  logic cts;

  uart_recv_if ifc ();

  uart_recv #(.OVERSAMPLE(OS)) dut (
    .uart_sampling_clk(clk),
    .rst              (rst),
    .USB_RX           (usb_rx),
    .USB_CTS          (cts),
    .rx_if            (ifc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Event monitor, sampled on the falling edge
  int         n_load = 0, n_ferr = 0, n_ovr = 0, n_ack = 0, n_res = 0;
  logic [7:0] last_data = 8'h00;
  int         last_load_cyc = 0;
  logic       vld_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.data_valid && !vld_prev) begin
        n_load++;
        last_data     = ifc.data_out;
        last_load_cyc = cyc;
      end
      if (ifc.frame_err) n_ferr++;
      if (ifc.overrun)   n_ovr++;
      if (ifc.rx_ack)    n_ack++;
      if (ifc.rx_resend) n_res++;
    end
    vld_prev = ifc.data_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    usb_rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int frame_start_cyc = 0;

  // Drives nbits bit-times of a frame (10 = complete); glitch flips sample 8 of every data bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch, input int nbits);
    logic [9:0] bits;
    logic       v;
    bits = {stop, d, 1'b0};
    @(posedge clk);
    #1;
    frame_start_cyc = cyc;
    for (int k = 0; k < nbits; k++) begin
      for (int i = 0; i < OS; i++) begin
        v = bits[k];
        if (glitch && k >= 1 && k <= 8 && i == OS / 2) v = ~v;
        usb_rx = v;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input logic stop, input bit glitch,
                          input int el, input logic [7:0] ed, input int ef, input int eo,
                          input int ea, input int er);
    int l0, f0, o0, a0, r0;
    l0 = n_load; f0 = n_ferr; o0 = n_ovr; a0 = n_ack; r0 = n_res;
    send_frame(d, stop, glitch, 10);
    idle(12);
    chk({tag, "_load"},    n_load - l0, el);
    if (el != 0) begin
      chk({tag, "_data"},    int'(last_data), int'(ed));
      chk({tag, "_latency"}, last_load_cyc - frame_start_cyc, LATENCY);
    end
    chk({tag, "_frame_err"}, n_ferr - f0, ef);
    chk({tag, "_overrun"},   n_ovr - o0, eo);
    chk({tag, "_rx_ack"},    n_ack - a0, ea);
    chk({tag, "_rx_resend"}, n_res - r0, er);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"},   int'(ifc.data_out), 0);
    chk({tag, "_data_valid"}, int'(ifc.data_valid), 0);
    chk({tag, "_USB_CTS"},    int'(cts), 0);
    chk({tag, "_frame_err"},  int'(ifc.frame_err), 0);
    chk({tag, "_overrun"},    int'(ifc.overrun), 0);
    chk({tag, "_rx_ack"},     int'(ifc.rx_ack), 0);
    chk({tag, "_rx_resend"},  int'(ifc.rx_resend), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_load;
    int         exp_ferr;
    int         exp_ack;
    int         exp_res;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] rd;
    logic       rs;
    logic [7:0] glitch_exp;
    int         o0, l0;

    tbl[0] = '{8'h5A, 1'b1, 1, 0, 0, 0};
    tbl[1] = '{8'hAA, 1'b1, 1, 0, 1, 0};
    tbl[2] = '{8'hCC, 1'b1, 1, 0, 0, 1};
    tbl[3] = '{8'h81, 1'b0, 0, 1, 0, 0};
    tbl[4] = '{8'h7E, 1'b1, 1, 0, 0, 0};
    tbl[5] = '{8'h00, 1'b1, 1, 0, 0, 0};

    ifc.data_ready = 1'b1;
    rst            = 1'b1;
    usb_rx         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle(10);

    for (int i = 0; i < 6; i++)
      do_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop, 1'b0,
               tbl[i].exp_load, tbl[i].d, tbl[i].exp_ferr, 0, tbl[i].exp_ack, tbl[i].exp_res);

    // Short low glitch must be rejected as a false start
    l0 = n_load; o0 = n_ferr;
    usb_rx = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    idle(40);
    chk("glitch_no_load", n_load - l0, 0);
    chk("glitch_no_ferr", n_ferr - o0, 0);
    chk("glitch_cts", int'(cts), 0);
    do_frame("after_glitch", 8'h33, 1'b1, 1'b0, 1, 8'h33, 0, 0, 0, 0);

    // Buffer full: second byte overruns, buffer keeps the first
    ifc.data_ready = 1'b0;
    do_frame("ovr_first", 8'h11, 1'b1, 1'b0, 1, 8'h11, 0, 0, 0, 0);
    chk("ovr_first_cts", int'(cts), 1);
    do_frame("ovr_second", 8'h22, 1'b1, 1'b0, 0, 8'h00, 0, 1, 0, 0);
    chk("ovr_hold_data", int'(ifc.data_out), 8'h11);
    chk("ovr_hold_valid", int'(ifc.data_valid), 1);
    chk("ovr_hold_cts", int'(cts), 1);
    ifc.data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", int'(ifc.data_valid), 0);
    chk("release_cts", int'(cts), 0);
    idle(4);

    // Reset mid-frame with a byte held in the buffer
    ifc.data_ready = 1'b0;
    do_frame("pre_reset", 8'h5A, 1'b1, 1'b0, 1, 8'h5A, 0, 0, 0, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 5);
    rst    = 1'b1;
    usb_rx = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midframe_rst");
    repeat (3) @(posedge clk);
    #1;
    rst            = 1'b0;
    ifc.data_ready = 1'b1;
    idle(20);
    do_frame("after_reset", 8'hF0, 1'b1, 1'b0, 1, 8'hF0, 0, 0, 0, 0);

    // One-sample glitch at mid-bit of every data bit
`ifdef UART_RECV_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'hFF;
`endif
    do_frame("midbit_glitch", 8'h00, 1'b1, 1'b1, 1, glitch_exp, 0, 0, 0, 0);

    // Random frames: the expected outcome follows from the byte and stop bit alone
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      if (i % 6 == 1) rd = 8'hAA;
      if (i % 6 == 4) rd = 8'hCC;
      rs = ($urandom_range(0, 7) != 0);
      do_frame($sformatf("rnd%0d", i), rd, rs, 1'b0,
               rs ? 1 : 0, rd, rs ? 0 : 1, 0,
               (rs && rd == 8'hAA) ? 1 : 0, (rs && rd == 8'hCC) ? 1 : 0);
      idle($urandom_range(0, 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
